// File: rtl/gc_stim_pkg.sv
// Shared types and default sizing for the gC stimulus controller.
// DRAIN exists only when GC_STIM_TIMEOUT_EN is defined.
package gc_stim_pkg;

    localparam int SKEW_W_DEF  = 8;
    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE2   = 3'd1,
        WAIT_HI = 3'd2,
        FALL2   = 3'd3,
        WAIT_LO = 3'd4,
        RESP    = 3'd5
`ifdef GC_STIM_TIMEOUT_EN
        ,
        DRAIN   = 3'd6
`endif
    } state_t;

endpackage

// File: rtl/gc_stimulus_if.sv
// Command/response handshake between a requester and the gC stimulus controller.
interface gc_stimulus_if import gc_stim_pkg::*; #(
    parameter int SKEW_W = SKEW_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_order;
    logic [SKEW_W-1:0] cmd_skew;
    logic              rsp_valid;
    logic              rsp_timeout;
    logic [CNT_W-1:0]  rsp_latency;

    modport master (
        output cmd_valid, cmd_order, cmd_skew,
        input  cmd_ready, rsp_valid, rsp_timeout, rsp_latency
    );

    modport slave (
        input  cmd_valid, cmd_order, cmd_skew,
        output cmd_ready, rsp_valid, rsp_timeout, rsp_latency
    );
endinterface

// File: rtl/gc_sync2.sv
// Two-flop synchronizer for the asynchronous Actuator return.
module gc_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/gc_stimulus.sv
// Drives Start/Sensor into a gC element with a programmable skew and times the Actuator reply.
// Optional abort on a stuck Actuator is enabled by defining GC_STIM_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a command
// RISE2   | leading input high, counting skew before raising the trailing one
// WAIT_HI | both inputs high, waiting for Actuator=1
// FALL2   | leading input low, counting skew before dropping the trailing one
// WAIT_LO | both inputs low, waiting for Actuator=0
// RESP    | one-cycle completion response
// DRAIN   | aborted, waiting for Actuator to return low (timeout build only)
module gc_stimulus import gc_stim_pkg::*; #(
    parameter int SKEW_W  = SKEW_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    gc_stimulus_if.slave bus,
    output logic        Start,
    output logic        Sensor,
    input  logic        Actuator
);
    state_t            state, state_nxt;
    logic              lead_q, lead_nxt, trail_q, trail_nxt;
    logic              order_q;
    logic [SKEW_W-1:0] skew_q, skew_cnt, skew_cnt_nxt;
    logic [CNT_W-1:0]  lat_cnt;
    logic              rdy_q, rsp_q, rsp_nxt;
    logic              act_sync, accept;

    gc_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(Actuator), .q(act_sync));

    assign accept          = bus.cmd_valid && rdy_q;
    assign Start           = order_q ? trail_q : lead_q;
    assign Sensor          = order_q ? lead_q  : trail_q;
    assign bus.cmd_ready   = rdy_q;
    assign bus.rsp_valid   = rsp_q;
    assign bus.rsp_latency = lat_cnt;

`ifdef GC_STIM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    logic          tmo_q, tmo_nxt;

    // Reloaded on every state change, so it restarts on entry to each wait state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  wait_cnt <= '0;
        else if (state_nxt != state) wait_cnt <= TW'(TIMEOUT - 1);
        else if (wait_cnt != '0)     wait_cnt <= wait_cnt - 1'b1;
    end

    assign bus.rsp_timeout = tmo_q;
`else
    logic unused_timeout;
    assign unused_timeout  = (TIMEOUT != 0);
    assign bus.rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        lead_nxt     = lead_q;
        trail_nxt    = trail_q;
        skew_cnt_nxt = skew_cnt;
        rsp_nxt      = 1'b0;
`ifdef GC_STIM_TIMEOUT_EN
        tmo_nxt      = 1'b0;
`endif
        case (state)
            IDLE: if (accept) begin
                lead_nxt = 1'b1;
                if (bus.cmd_skew == '0) begin
                    trail_nxt = 1'b1;
                    state_nxt = WAIT_HI;
                end else begin
                    skew_cnt_nxt = bus.cmd_skew - 1'b1;
                    state_nxt    = RISE2;
                end
            end
            RISE2: if (skew_cnt == '0) begin
                trail_nxt = 1'b1;
                state_nxt = WAIT_HI;
            end else begin
                skew_cnt_nxt = skew_cnt - 1'b1;
            end
            WAIT_HI: begin
                if (act_sync) begin
                    lead_nxt = 1'b0;
                    if (skew_q == '0) begin
                        trail_nxt = 1'b0;
                        state_nxt = WAIT_LO;
                    end else begin
                        skew_cnt_nxt = skew_q - 1'b1;
                        state_nxt    = FALL2;
                    end
                end
`ifdef GC_STIM_TIMEOUT_EN
                else if (wait_cnt == '0) begin
                    lead_nxt  = 1'b0;
                    trail_nxt = 1'b0;
                    rsp_nxt   = 1'b1;
                    tmo_nxt   = 1'b1;
                    state_nxt = DRAIN;
                end
`endif
            end
            FALL2: if (skew_cnt == '0) begin
                trail_nxt = 1'b0;
                state_nxt = WAIT_LO;
            end else begin
                skew_cnt_nxt = skew_cnt - 1'b1;
            end
            WAIT_LO: begin
                if (!act_sync) begin
                    rsp_nxt   = 1'b1;
                    state_nxt = RESP;
                end
`ifdef GC_STIM_TIMEOUT_EN
                else if (wait_cnt == '0) begin
                    rsp_nxt   = 1'b1;
                    tmo_nxt   = 1'b1;
                    state_nxt = DRAIN;
                end
`endif
            end
            RESP: state_nxt = IDLE;
`ifdef GC_STIM_TIMEOUT_EN
            DRAIN: if (!act_sync) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // rdy_q follows the next state so cmd_ready stays low while rst_n is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lead_q   <= 1'b0;
            trail_q  <= 1'b0;
            order_q  <= 1'b0;
            skew_q   <= '0;
            skew_cnt <= '0;
            lat_cnt  <= '0;
            rdy_q    <= 1'b0;
            rsp_q    <= 1'b0;
`ifdef GC_STIM_TIMEOUT_EN
            tmo_q    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            lead_q   <= lead_nxt;
            trail_q  <= trail_nxt;
            skew_cnt <= skew_cnt_nxt;
            rdy_q    <= (state_nxt == IDLE);
            rsp_q    <= rsp_nxt;
`ifdef GC_STIM_TIMEOUT_EN
            tmo_q    <= tmo_nxt;
`endif
            if (accept) begin
                order_q <= bus.cmd_order;
                skew_q  <= bus.cmd_skew;
                lat_cnt <= '0;
            end else if (state != IDLE && lat_cnt != '1) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
        end
    end
endmodule
